// File: rtl/count_display.sv
`default_nettype none
// ============================================================================
// Module   : count_display
// Brief    : 6-bit count to BCD (shift-add-3) with 2-digit multiplexed
//            common-anode seven-segment drive and a BCD result strobe.
// Revision : 1.0
// ============================================================================
module count_display #(
    parameter logic [15:0] SCAN_DIV = 16'd50000,
    parameter logic        BLANK_LZ = 1'b1
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic [5:0] value,
    output logic [7:0] bcd,
    output logic       bcd_valid,
    output logic       busy,
    output logic [6:0] seg,
    output logic [1:0] an
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_LOAD    = 2'd2
    } state_t;

    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
    localparam logic [2:0] c_NUM_BITS  = 3'd6;

    state_t      r_state;
    logic [5:0]  r_snap;
    logic [5:0]  r_shift;
    logic [7:0]  r_acc;
    logic [2:0]  r_cnt;
    logic        r_force;
    logic [15:0] r_presc;
    logic        r_sel;

    logic [7:0]  w_acc_adj;
    logic [3:0]  w_digit;
    logic        w_blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = c_SEG_BLANK;
        endcase
        return s;
    endfunction

    always_comb begin
        w_acc_adj[3:0] = (r_acc[3:0] >= 4'd5) ? r_acc[3:0] + 4'd3 : r_acc[3:0];
        w_acc_adj[7:4] = (r_acc[7:4] >= 4'd5) ? r_acc[7:4] + 4'd3 : r_acc[7:4];
        w_digit        = r_sel ? bcd[7:4] : bcd[3:0];
        w_blank        = r_sel & BLANK_LZ & (bcd[7:4] == 4'd0);
    end

    // Converter: bcd only ever loads from the accumulator in ST_LOAD, so an
    // aborted conversion can never leak a partial result.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_snap    <= 6'h00;
            r_shift   <= 6'h00;
            r_acc     <= 8'h00;
            r_cnt     <= 3'd0;
            r_force   <= 1'b1;
            bcd       <= 8'h00;
            bcd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_force || (value != r_snap)) begin
                        r_snap  <= value;
                        r_shift <= value;
                        r_acc   <= 8'h00;
                        r_cnt   <= c_NUM_BITS;
                        r_force <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    {r_acc, r_shift} <= {w_acc_adj, r_shift} << 1;
                    r_cnt            <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    bcd       <= r_acc;
                    bcd_valid <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Display scan runs free of the converter; seg/an follow r_sel one cycle late.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= 16'd0;
            r_sel   <= 1'b0;
            seg     <= c_SEG_BLANK;
            an      <= 2'b11;
        end else begin
            if (r_presc == SCAN_DIV - 16'd1) begin
                r_presc <= 16'd0;
                r_sel   <= ~r_sel;
            end else begin
                r_presc <= r_presc + 16'd1;
            end
            an  <= r_sel ? 2'b01 : 2'b10;
            seg <= w_blank ? c_SEG_BLANK : decode(w_digit);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_count_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_display
// Brief    : Directed self-checking bench for count_display (two instances,
//            leading-zero blanking on and off).
// Revision : 1.0
// ============================================================================
module tb_count_display;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] value = 6'd0;

    logic [7:0] bcd_a, bcd_b;
    logic       bcd_valid_a, bcd_valid_b;
    logic       busy_a, busy_b;
    logic [6:0] seg_a, seg_b;
    logic [1:0] an_a, an_b;

    int tests_run = 0;
    int fails     = 0;

    always #5 clock = ~clock;

    count_display #(.SCAN_DIV(16'd4), .BLANK_LZ(1'b1)) dut_a (
        .clock(clock), .rst_n(rst_n), .value(value),
        .bcd(bcd_a), .bcd_valid(bcd_valid_a), .busy(busy_a),
        .seg(seg_a), .an(an_a)
    );

    count_display #(.SCAN_DIV(16'd4), .BLANK_LZ(1'b0)) dut_b (
        .clock(clock), .rst_n(rst_n), .value(value),
        .bcd(bcd_b), .bcd_valid(bcd_valid_b), .busy(busy_b),
        .seg(seg_b), .an(an_b)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_slot(input logic [1:0] want, output logic seen);
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            tick();
            if (an_a == want) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        int pulses;
        int valid_at;
        logic [7:0] bcd_seen;
        logic seen;
        rst_n = 1'b0;
        value = 6'd0;
        repeat (3) @(posedge clock);
        #1;
        tests_run++;
        if (bcd_a !== 8'h00 || bcd_valid_a !== 1'b0 || busy_a !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: bcd=%h valid=%b busy=%b, need 00/0/0", bcd_a, bcd_valid_a, busy_a);
        end
        tests_run++;
        if (seg_a !== 7'b1111111 || an_a !== 2'b11) begin
            fails++;
            $display("FAIL reset_disp: seg=%b an=%b, need 1111111/11", seg_a, an_a);
        end
        #3 rst_n = 1'b1;
        pulses = 0; valid_at = 0; bcd_seen = 8'hxx;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (bcd_valid_a) begin
                pulses++;
                valid_at = k;
                bcd_seen = bcd_a;
            end
        end
        tests_run++;
        if (pulses != 1 || valid_at != 8 || bcd_seen !== 8'h00) begin
            fails++;
            $display("FAIL reset_conv: pulses=%0d at=%0d bcd=%h, need 1 at 8 bcd=00", pulses, valid_at, bcd_seen);
        end
        wait_slot(2'b10, seen);
        tests_run++;
        if (!seen || seg_a !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_ones: seen=%b seg=%b, need 1000000", seen, seg_a);
        end
        wait_slot(2'b01, seen);
        tests_run++;
        if (!seen || seg_a !== 7'b1111111) begin
            fails++;
            $display("FAIL reset_tens: seen=%b seg=%b, need 1111111", seen, seg_a);
        end
    endtask

    task automatic test_max();
        int pulses;
        int valid_at;
        logic [7:0] bcd_seen;
        logic seen;
        value = 6'd63;
        pulses = 0; valid_at = 0; bcd_seen = 8'hxx;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bcd_valid_a) begin
                pulses++;
                valid_at = k;
                bcd_seen = bcd_a;
            end
        end
        tests_run++;
        if (pulses != 1 || valid_at != 8 || bcd_seen !== 8'h63) begin
            fails++;
            $display("FAIL max_conv: pulses=%0d at=%0d bcd=%h, need 1 at 8 bcd=63", pulses, valid_at, bcd_seen);
        end
        wait_slot(2'b01, seen);
        tests_run++;
        if (!seen || seg_a !== 7'b0000010) begin
            fails++;
            $display("FAIL max_tens: seen=%b seg=%b, need 0000010", seen, seg_a);
        end
        wait_slot(2'b10, seen);
        tests_run++;
        if (!seen || seg_a !== 7'b0110000) begin
            fails++;
            $display("FAIL max_ones: seen=%b seg=%b, need 0110000", seen, seg_a);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int at1, at2, busy_low;
        logic [7:0] b1, b2;
        pulses = 0; at1 = 0; at2 = 0; busy_low = 0; b1 = 8'hxx; b2 = 8'hxx;
        value = 6'd42;
        for (int k = 1; k <= 26; k++) begin
            tick();
            if (k == 3) value = 6'd17;
            if (k <= 15 && !busy_a) busy_low++;
            if (bcd_valid_a) begin
                pulses++;
                if (pulses == 1) begin at1 = k; b1 = bcd_a; end
                if (pulses == 2) begin at2 = k; b2 = bcd_a; end
            end
        end
        tests_run++;
        if (at1 != 8 || b1 !== 8'h42) begin
            fails++;
            $display("FAIL b2b_first: at=%0d bcd=%h, need at 8 bcd=42", at1, b1);
        end
        tests_run++;
        if (pulses != 2 || at2 != at1 + 8 || b2 !== 8'h17) begin
            fails++;
            $display("FAIL b2b_second: pulses=%0d at=%0d bcd=%h, need 2 pulses, at %0d bcd=17", pulses, at2, b2, at1 + 8);
        end
        tests_run++;
        if (busy_low != 1) begin
            fails++;
            $display("FAIL b2b_busy_gap: low cycles=%0d, need 1", busy_low);
        end
    endtask

    task automatic test_scan();
        int bad;
        logic [1:0] exp_an;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (an_a !== 2'b11 || seg_a !== 7'b1111111) begin
            fails++;
            $display("FAIL scan_in_reset: an=%b seg=%b, need 11/1111111", an_a, seg_a);
        end
        tick();
        tests_run++;
        if (an_a !== 2'b11) begin
            fails++;
            $display("FAIL scan_held_reset: an=%b, need 11", an_a);
        end
        #3 rst_n = 1'b1;
        bad = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_an = (((i - 1) / 4) % 2 == 1) ? 2'b01 : 2'b10;
            tests_run++;
            if (an_a !== exp_an) begin
                fails++;
                bad++;
                $display("FAIL scan_an[%0d]: an=%b, need %b", i, an_a, exp_an);
            end
        end
    endtask

    task automatic test_blank();
        logic seen;
        value = 6'd9;
        repeat (12) tick();
        wait_slot(2'b01, seen);
        tests_run++;
        if (!seen || seg_a !== 7'b1111111) begin
            fails++;
            $display("FAIL blank9_lz1: seen=%b seg=%b, need 1111111", seen, seg_a);
        end
        tests_run++;
        if (an_b !== 2'b01 || seg_b !== 7'b1000000) begin
            fails++;
            $display("FAIL blank9_lz0: an=%b seg=%b, need 01/1000000", an_b, seg_b);
        end
        value = 6'd10;
        repeat (12) tick();
        wait_slot(2'b01, seen);
        tests_run++;
        if (!seen || seg_a !== 7'b1111001) begin
            fails++;
            $display("FAIL blank10_tens: seen=%b seg=%b, need 1111001", seen, seg_a);
        end
        wait_slot(2'b10, seen);
        tests_run++;
        if (!seen || seg_a !== 7'b1000000) begin
            fails++;
            $display("FAIL blank10_ones: seen=%b seg=%b, need 1000000", seen, seg_a);
        end
    endtask

    task automatic test_async_reset();
        int pulses;
        int valid_at;
        logic [7:0] bcd_seen;
        value = 6'd45;
        repeat (3) tick();
        tests_run++;
        if (busy_a !== 1'b1) begin
            fails++;
            $display("FAIL arst_busy_before: busy=%b, need 1", busy_a);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bcd_a !== 8'h00 || bcd_valid_a !== 1'b0 || busy_a !== 1'b0) begin
            fails++;
            $display("FAIL arst_ctrl: bcd=%h valid=%b busy=%b, need 00/0/0", bcd_a, bcd_valid_a, busy_a);
        end
        tests_run++;
        if (seg_a !== 7'b1111111 || an_a !== 2'b11) begin
            fails++;
            $display("FAIL arst_disp: seg=%b an=%b, need 1111111/11", seg_a, an_a);
        end
        #2 rst_n = 1'b1;
        pulses = 0; valid_at = 0; bcd_seen = 8'hxx;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (bcd_valid_a) begin
                pulses++;
                valid_at = k;
                bcd_seen = bcd_a;
            end
        end
        tests_run++;
        if (pulses != 1 || valid_at != 8 || bcd_seen !== 8'h45) begin
            fails++;
            $display("FAIL arst_conv: pulses=%0d at=%0d bcd=%h, need 1 at 8 bcd=45", pulses, valid_at, bcd_seen);
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_back_to_back();
        test_scan();
        test_blank();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/count_display.md
Name: count_display

Overview:
- Downstream consumer of the 6-bit up/down counter in the counter scope design.
- Converts the unsigned count (0..63) to two BCD digits with a sequential shift-add-3 converter.
- Drives a time-multiplexed 2-digit common-anode seven-segment display: active-low segments, active-low digit enables.
- Also exports the BCD result with a valid strobe for other consumers.

Parameters:
- SCAN_DIV, 16'd50000: clocks per digit slot (refresh prescaler terminal count); legal 2..65535.
- BLANK_LZ, 1'b1: 1 blanks the tens digit when it is 0.

Ports:
- clock  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- value  input  6  unsigned count from the counter stage
- bcd  output  8  last converted result, [7:4] tens, [3:0] ones
- bcd_valid  output  1  one-cycle pulse when bcd is updated
- busy  output  1  high while the converter is in CONVERT or LOAD
- seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}
- an  output  2  digit enables, active-low, an[0] ones, an[1] tens

Behaviour:
- Reset, asynchronous on rst_n low:
  - bcd=8'h00, bcd_valid=0, busy=0, seg=7'b1111111, an=2'b11.
  - Prescaler=0, digit select=0 (ones), snapshot register=6'h00.
  - A force_conv flag is set.
  - Any conversion in flight is aborted. No partial result ever reaches bcd.
- Converter FSM states: IDLE, CONVERT, LOAD.
- IDLE:
  - If force_conv is set or value != snapshot, latch value into snapshot and into the shift register.
  - On that transition: clear the BCD accumulator, set bit count to 6, clear force_conv, go to CONVERT.
  - Otherwise stay in IDLE.
- CONVERT, one iteration per clock:
  - Add 3 to each BCD nibble that is >= 5.
  - Shift {bcd_acc, shift} left by 1.
  - Decrement the bit count. Go to LOAD after the 6th iteration.
- LOAD: bcd <= accumulator, bcd_valid=1 for exactly this one cycle, return to IDLE.
- Latency:
  - IDLE samples the change at edge N.
  - bcd is updated and bcd_valid is high after edge N+7.
  - The display uses the new digits from edge N+8 onward.
- busy is high from the edge after sampling through the LOAD cycle (7 cycles).
- value changes during CONVERT/LOAD are ignored. On return to IDLE the new value differs from snapshot and triggers a fresh conversion. Intermediate values may be skipped; the final value is always displayed.
- Width rules:
  - Tens nibble never exceeds 6; ones nibble never exceeds 9.
  - Codes A..F cannot occur. If present, the decoder outputs blank (7'b1111111).
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - At terminal count the digit select toggles.
  - seg and an are registered and reflect the select one cycle after it changes.
  - select=0: an=2'b10, seg=decode(bcd[3:0]).
  - select=1: an=2'b01, seg=decode(bcd[7:4]), or blank if BLANK_LZ and bcd[7:4]==0.
- Scanning runs independently of the converter. A bcd update mid-slot takes effect on the next registered seg value.
- Decode table, active-low gfedcba:

| Digit | seg |
|---|---|
| 0 | 1000000 |
| 1 | 1111001 |
| 2 | 0100100 |
| 3 | 0110000 |
| 4 | 0011001 |
| 5 | 0010010 |
| 6 | 0000010 |
| 7 | 1111000 |
| 8 | 0000000 |
| 9 | 0010000 |

Test Plan:
1. Reset release, value=0, SCAN_DIV=4:
   - Exactly one bcd_valid pulse 7 cycles after the first post-reset edge, bcd=8'h00.
   - Ones slot shows seg=1000000, an=2'b10.
   - Tens slot shows seg=1111111, an=2'b01.
2. value=63 held:
   - bcd=8'h63, one bcd_valid pulse.
   - Tens slot seg=0000010, ones slot seg=0110000.
   - No further pulses while value is stable.
3. value 42, then 17 applied 3 cycles into CONVERT:
   - bcd_valid pulses with bcd=8'h42.
   - A second pulse follows with bcd=8'h17 exactly 8 cycles later.
   - busy is low for exactly 1 cycle between the two conversions.
4. Scan timing, SCAN_DIV=4: an sequence 10,10,10,10,01,01,01,01 repeating. Never 00 after reset. 11 only during reset.
5. value 9 -> 10 with BLANK_LZ=1:
   - Tens slot goes from 1111111 to 1111001.
   - With BLANK_LZ=0 the tens slot shows 1000000 for value 9.
6. rst_n asserted mid-CONVERT on 45, asynchronous to clock:
   - Outputs reach reset values without a clock edge.
   - After release, bcd_valid fires once with bcd=8'h45 (forced conversion).
